// File: rtl/spi_cfg_pkg.sv
// Shared types and constants for the SPI configuration register file.
package spi_cfg_pkg;
  typedef enum logic [1:0] {IDLE, HDR, DATA, OVR} spi_state_t;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  function automatic int frame_bits(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction
endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchroniser plus one history flop giving single-cycle edge pulses.
module sync_edge_det #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic sync_out,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_in};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign sync_out = sync_q[STAGES-1];
  assign rise     = sync_out & ~prev_q;
  assign fall     = ~sync_out & prev_q;
endmodule

// File: rtl/spi_cfg_regfile.sv
// SPI mode-0 configuration register file, oversampled on the system clock.
// Frames are RW, address, data (MSB first); writes commit only on exact length.
module spi_cfg_regfile import spi_cfg_pkg::*; #(
  parameter int DATA_W      = 8,
  parameter int N_REGS      = 16,
  parameter int ADDR_W      = $clog2(N_REGS),
  parameter int SYNC_STAGES = 2,
  parameter logic [N_REGS*DATA_W-1:0] RST_VAL = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     SCLK,
  input  logic                     CS,
  input  logic                     SDI,
  output logic                     SDO,
  output logic                     SDO_OE,
  output logic [N_REGS*DATA_W-1:0] cfg_regs,
  output logic                     wr_strobe,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic                     frame_err
);
  localparam int F     = frame_bits(ADDR_W, DATA_W);
  localparam int CNT_W = $clog2(F + 1);
  localparam logic [CNT_W-1:0]  F_C  = CNT_W'(F);
  localparam logic [CNT_W-1:0]  HB_C = CNT_W'(1 + ADDR_W);
  localparam logic [ADDR_W:0]   NR_C = (ADDR_W+1)'(N_REGS);

  logic sclk_rise, sclk_fall, cs_s, cs_rise, cs_fall, sdi_s;
  logic unused_sclk_s, unused_sdi_rise, unused_sdi_fall;

  sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .reset(reset), .async_in(SCLK),
    .sync_out(unused_sclk_s), .rise(sclk_rise), .fall(sclk_fall));
  sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync_cs (
    .clk(clk), .reset(reset), .async_in(CS),
    .sync_out(cs_s), .rise(cs_rise), .fall(cs_fall));
  sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync_sdi (
    .clk(clk), .reset(reset), .async_in(SDI),
    .sync_out(sdi_s), .rise(unused_sdi_rise), .fall(unused_sdi_fall));

  spi_state_t                   state_q, state_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic                         ovf_q, ovf_d, rw_q, rw_d;
  logic [F-1:0]                 sr_q, sr_d;
  logic [ADDR_W-1:0]            addr_q, addr_d;
  logic [DATA_W-1:0]            tx_q, tx_d;
  logic                         cm_q, cm_d, er_q, er_d, sdo_d, oe_d;
  logic                         sample, eof, addr_ok, frame_ok;
  logic [N_REGS-1:0][DATA_W-1:0] regs_q;

  // A bit landing in the same cycle as CS rising still counts toward the frame.
  assign sample = sclk_rise && (!cs_s || cs_rise) && state_q != IDLE && !cs_fall;
  assign eof    = cs_rise && state_q != IDLE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (cs_fall)  state_d = HDR;
    else if (eof) state_d = IDLE;
    else if (sample) begin
      case (state_q)
        HDR:     if (cnt_q + 1'b1 == HB_C) state_d = DATA;
        DATA:    if (cnt_q + 1'b1 == F_C)  state_d = OVR;
        default: ;
      endcase
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    sr_d   = sr_q;
    rw_d   = rw_q;
    addr_d = addr_q;
    tx_d   = tx_q;
    if (cs_fall) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (sample) begin
      sr_d = {sr_q[F-2:0], sdi_s};
      if (state_q == OVR) ovf_d = 1'b1;
      else                cnt_d = cnt_q + 1'b1;
      if (state_q == HDR && cnt_d == HB_C) begin
        rw_d   = sr_d[ADDR_W];
        addr_d = sr_d[ADDR_W-1:0];
        tx_d   = (rw_d == RW_READ && {1'b0, addr_d} < NR_C) ? regs_q[addr_d] : '0;
      end
    // The fall right after the load must not shift, or the MSB never reaches the pin.
    end else if (sclk_fall && state_q == DATA && cnt_q > HB_C) begin
      tx_d = {tx_q[DATA_W-2:0], 1'b0};
    end
  end

  assign addr_ok  = {1'b0, addr_d} < NR_C;
  assign frame_ok = cnt_d == F_C && !ovf_d;
  assign cm_d     = eof && frame_ok && rw_d == RW_WRITE && addr_ok;
  assign er_d     = eof && !cm_d && !(frame_ok && rw_d == RW_READ);

  always_comb begin
    oe_d  = (state_d == DATA || state_d == OVR) && rw_d == RW_READ;
    sdo_d = (state_d == DATA && rw_d == RW_READ) ? tx_d[DATA_W-1] : 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      sr_q      <= '0;
      rw_q      <= RW_WRITE;
      addr_q    <= '0;
      tx_q      <= '0;
      cm_q      <= 1'b0;
      er_q      <= 1'b0;
      SDO       <= 1'b0;
      SDO_OE    <= 1'b0;
      wr_strobe <= 1'b0;
      frame_err <= 1'b0;
      wr_addr   <= '0;
      regs_q    <= RST_VAL;
    end else begin
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      sr_q      <= sr_d;
      rw_q      <= rw_d;
      addr_q    <= addr_d;
      tx_q      <= tx_d;
      cm_q      <= cm_d;
      er_q      <= er_d;
      SDO       <= sdo_d;
      SDO_OE    <= oe_d;
      wr_strobe <= cm_q;
      frame_err <= er_q;
      // Frame data and address stay parked in IDLE for the cycle after evaluation.
      if (cm_q) begin
        regs_q[addr_q] <= sr_q[DATA_W-1:0];
        wr_addr        <= addr_q;
      end
    end
  end

  assign cfg_regs = regs_q;
endmodule

// File: tb/tb_spi_cfg_regfile.sv
// Randomised and directed checks of spi_cfg_regfile against a register-array model.
module tb_spi_cfg_regfile;
  localparam int DW = 8, NA = 16, NB = 12, SS = 2, FB = 13;

  function automatic logic [127:0] pat(input int n);
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[i*8 +: 8] = 8'(i + 1);
    return v;
  endfunction
  localparam logic [127:0] RST_A = pat(NA);
  localparam logic [95:0]  RST_B = RST_A[95:0];

  typedef struct {
    logic [7:0] rd;
    int n_ws, ws_cyc, n_fe, fe_cyc, oe_bad;
    logic [3:0] wa;
  } obs_t;

  logic clk = 1'b0, reset = 1'b1, SCLK = 1'b0, SDI = 1'b0, cs_a = 1'b1, cs_b = 1'b1;
  logic sdo_a, oe_a, ws_a, fe_a, sdo_b, oe_b, ws_b, fe_b;
  logic [3:0] wa_a, wa_b;
  logic [127:0] regs_a;
  logic [95:0]  regs_b;
  logic [7:0] m_a [NA];
  logic [7:0] m_b [NB];
  int passed = 0, total = 0;

  always #5 clk = ~clk;

  spi_cfg_regfile #(.DATA_W(DW), .N_REGS(NA), .SYNC_STAGES(SS), .RST_VAL(RST_A)) dut_a (
    .clk(clk), .reset(reset), .SCLK(SCLK), .CS(cs_a), .SDI(SDI), .SDO(sdo_a), .SDO_OE(oe_a),
    .cfg_regs(regs_a), .wr_strobe(ws_a), .wr_addr(wa_a), .frame_err(fe_a));
  spi_cfg_regfile #(.DATA_W(DW), .N_REGS(NB), .SYNC_STAGES(SS), .RST_VAL(RST_B)) dut_b (
    .clk(clk), .reset(reset), .SCLK(SCLK), .CS(cs_b), .SDI(SDI), .SDO(sdo_b), .SDO_OE(oe_b),
    .cfg_regs(regs_b), .wr_strobe(ws_b), .wr_addr(wa_b), .frame_err(fe_b));

  function automatic logic [127:0] flat_a();
    logic [127:0] v;
    for (int i = 0; i < NA; i++) v[i*8 +: 8] = m_a[i];
    return v;
  endfunction
  function automatic logic [95:0] flat_b();
    logic [95:0] v;
    for (int i = 0; i < NB; i++) v[i*8 +: 8] = m_b[i];
    return v;
  endfunction
  function automatic void model_reset();
    for (int i = 0; i < NA; i++) m_a[i] = 8'(i + 1);
    for (int i = 0; i < NB; i++) m_b[i] = 8'(i + 1);
  endfunction

  // One SPI mode-0 frame at ~1/10 of clk; observes SDO/OE per bit and the pulses after CS rise.
  task automatic do_frame(input int sel, input logic rw, input logic [3:0] addr,
                          input logic [7:0] data, input int len, output obs_t o);
    logic [31:0] v;
    v = {rw, addr, data, 19'($urandom)};
    o.rd = '0; o.n_ws = 0; o.ws_cyc = 0; o.n_fe = 0; o.fe_cyc = 0; o.oe_bad = 0;
    @(negedge clk);
    if (sel != 0) cs_b = 1'b0; else cs_a = 1'b0;
    #50;
    for (int i = 0; i < len; i++) begin
      SDI = v[31-i];
      #50;
      if (i < FB) begin
        if (((sel != 0) ? oe_b : oe_a) !== (rw && i >= 5)) o.oe_bad++;
        if (i >= 5) o.rd[12-i] = (sel != 0) ? sdo_b : sdo_a;
      end
      SCLK = 1'b1; #50; SCLK = 1'b0;
    end
    #50;
    @(negedge clk);
    if (sel != 0) cs_b = 1'b1; else cs_a = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if ((sel != 0) ? ws_b : ws_a) begin o.n_ws++; o.ws_cyc = c; end
      if ((sel != 0) ? fe_b : fe_a) begin o.n_fe++; o.fe_cyc = c; end
    end
    o.wa = (sel != 0) ? wa_b : wa_a;
  endtask

  task automatic test_reset();
    int pulses;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (regs_a !== RST_A) $display("FAIL reset regs_a: got %h want %h", regs_a, RST_A); else passed++;
    total++; if (regs_b !== RST_B) $display("FAIL reset regs_b: got %h want %h", regs_b, RST_B); else passed++;
    total++; if ({oe_a, sdo_a, ws_a, fe_a} !== 4'b0) $display("FAIL reset outputs a: got %b want 0000", {oe_a, sdo_a, ws_a, fe_a}); else passed++;
    total++; if (wa_a !== 4'd0) $display("FAIL reset wr_addr: got %0d want 0", wa_a); else passed++;
    @(negedge clk); reset = 1'b0;
    pulses = 0;
    repeat (10) begin @(posedge clk); #1; pulses += int'(ws_a | fe_a | ws_b | fe_b | oe_a | oe_b); end
    total++; if (pulses != 0) $display("FAIL post-reset pulses: got %0d want 0", pulses); else passed++;
    model_reset();
  endtask

  task automatic test_write();
    obs_t o;
    do_frame(0, 1'b0, 4'd3, 8'hA5, FB, o);
    m_a[3] = 8'hA5;
    total++; if (o.n_ws != 1) $display("FAIL write strobe count: got %0d want 1", o.n_ws); else passed++;
    total++; if (o.ws_cyc != SS + 2) $display("FAIL write strobe latency: got %0d want %0d", o.ws_cyc, SS + 2); else passed++;
    total++; if (o.wa !== 4'd3) $display("FAIL write wr_addr: got %0d want 3", o.wa); else passed++;
    total++; if (o.n_fe != 0) $display("FAIL write frame_err: got %0d want 0", o.n_fe); else passed++;
    total++; if (regs_a !== flat_a()) $display("FAIL write regs: got %h want %h", regs_a, flat_a()); else passed++;
  endtask

  task automatic test_read();
    obs_t o;
    do_frame(0, 1'b1, 4'd3, 8'($urandom), FB, o);
    total++; if (o.rd !== 8'hA5) $display("FAIL read data: got %h want a5", o.rd); else passed++;
    total++; if (o.oe_bad != 0) $display("FAIL read sdo_oe bits: got %0d bad want 0", o.oe_bad); else passed++;
    total++; if (o.n_fe + o.n_ws != 0) $display("FAIL read pulses: got %0d want 0", o.n_fe + o.n_ws); else passed++;
    total++; if (oe_a !== 1'b0) $display("FAIL read oe after frame: got %b want 0", oe_a); else passed++;
    total++; if (regs_a !== flat_a()) $display("FAIL read regs: got %h want %h", regs_a, flat_a()); else passed++;
  endtask

  task automatic test_bad_len();
    obs_t o;
    for (int k = 0; k < 2; k++) begin
      do_frame(0, 1'b0, 4'd5, 8'h5A, (k == 0) ? 12 : 14, o);
      total++; if (o.n_fe != 1 || o.fe_cyc != SS + 2) $display("FAIL badlen%0d frame_err: got %0d@%0d want 1@%0d", k, o.n_fe, o.fe_cyc, SS + 2); else passed++;
      total++; if (o.n_ws != 0) $display("FAIL badlen%0d strobe: got %0d want 0", k, o.n_ws); else passed++;
    end
    total++; if (regs_a !== flat_a()) $display("FAIL badlen regs: got %h want %h", regs_a, flat_a()); else passed++;
  endtask

  task automatic test_cs_high_and_reset();
    obs_t o;
    int pulses;
    pulses = 0;
    repeat (20) begin
      SDI = 1'($urandom);
      SCLK = ~SCLK;
      repeat (5) begin @(posedge clk); #1; pulses += int'(ws_a | fe_a | oe_a); end
    end
    SCLK = 1'b0;
    total++; if (pulses != 0) $display("FAIL cs-high activity: got %0d want 0", pulses); else passed++;
    total++; if (regs_a !== flat_a()) $display("FAIL cs-high regs: got %h want %h", regs_a, flat_a()); else passed++;
    do_frame(0, 1'b0, 4'd7, 8'h3C, FB, o);
    m_a[7] = 8'h3C;
    total++; if (o.n_ws != 1 || regs_a !== flat_a()) $display("FAIL post-idle write: got %0d/%h want 1/%h", o.n_ws, regs_a, flat_a()); else passed++;
    // Read of reg2 cut off by reset after 6 bits (one into the data phase).
    @(negedge clk); cs_a = 1'b0; #50;
    for (int i = 0; i < 6; i++) begin
      SDI = (i == 0 || i == 3) ? 1'b1 : 1'b0;
      #50; SCLK = 1'b1; #50; SCLK = 1'b0;
    end
    #50;
    total++; if (oe_a !== 1'b1) $display("FAIL mid-frame oe: got %b want 1", oe_a); else passed++;
    @(negedge clk); reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    total++; if (regs_a !== RST_A || oe_a !== 1'b0 || sdo_a !== 1'b0) $display("FAIL mid-frame reset: got %h/%b want %h/0", regs_a, oe_a, RST_A); else passed++;
    cs_a = 1'b1;
    @(negedge clk); reset = 1'b0;
    repeat (8) @(posedge clk);
    do_frame(0, 1'b0, 4'd15, 8'hFF, FB, o);
    m_a[15] = 8'hFF;
    total++; if (o.n_ws != 1 || o.wa !== 4'd15) $display("FAIL reg15 commit: got %0d/%0d want 1/15", o.n_ws, o.wa); else passed++;
    total++; if (regs_a !== flat_a()) $display("FAIL reg15 regs: got %h want %h", regs_a, flat_a()); else passed++;
  endtask

  task automatic test_out_of_range();
    obs_t o;
    do_frame(1, 1'b0, 4'd13, 8'h77, FB, o);
    total++; if (o.n_fe != 1 || o.n_ws != 0) $display("FAIL oob write: got fe %0d ws %0d want 1 0", o.n_fe, o.n_ws); else passed++;
    total++; if (regs_b !== flat_b()) $display("FAIL oob regs: got %h want %h", regs_b, flat_b()); else passed++;
    do_frame(1, 1'b1, 4'd13, 8'h00, FB, o);
    total++; if (o.rd !== 8'h00 || o.n_fe != 0) $display("FAIL oob read: got %h fe %0d want 00 0", o.rd, o.n_fe); else passed++;
    do_frame(1, 1'b0, 4'd11, 8'hC3, FB, o);
    m_b[11] = 8'hC3;
    total++; if (o.n_ws != 1 || o.wa !== 4'd11 || regs_b !== flat_b()) $display("FAIL top-addr write: got %0d/%0d want 1/11", o.n_ws, o.wa); else passed++;
  endtask

  task automatic test_random();
    obs_t o;
    int sel, n, len, lens[7];
    logic rw, commit, err;
    logic [3:0] addr;
    logic [7:0] data, exp_rd;
    lens = '{11, 12, 13, 13, 13, 14, 15};
    for (int k = 0; k < 30; k++) begin
      sel = int'($urandom_range(0, 1));
      rw = 1'($urandom); addr = 4'($urandom); data = 8'($urandom);
      len = lens[$urandom_range(0, 6)];
      n = (sel != 0) ? NB : NA;
      commit = (len == FB) && !rw && (int'(addr) < n);
      err = !commit && !((len == FB) && rw);
      exp_rd = (int'(addr) >= n) ? 8'h00 : (sel != 0) ? m_b[addr] : m_a[addr];
      do_frame(sel, rw, addr, data, len, o);
      if (commit) begin
        if (sel != 0) m_b[addr] = data; else m_a[addr] = data;
      end
      total++; if (o.n_ws != int'(commit) || o.n_fe != int'(err)) $display("FAIL rand%0d pulses: got ws %0d fe %0d want %0d %0d", k, o.n_ws, o.n_fe, commit, err); else passed++;
      total++; if (regs_a !== flat_a() || regs_b !== flat_b()) $display("FAIL rand%0d regs: got %h %h want %h %h", k, regs_a, regs_b, flat_a(), flat_b()); else passed++;
      if (rw && len >= FB) begin
        total++; if (o.rd !== exp_rd || o.oe_bad != 0) $display("FAIL rand%0d read: got %h oe_bad %0d want %h 0", k, o.rd, o.oe_bad, exp_rd); else passed++;
      end
      if (commit) begin
        total++; if (o.wa !== addr || o.ws_cyc != SS + 2) $display("FAIL rand%0d wr_addr: got %0d@%0d want %0d@%0d", k, o.wa, o.ws_cyc, addr, SS + 2); else passed++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_bad_len();
    test_cs_high_and_reset();
    test_out_of_range();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/spi_cfg_regfile.md
Name: spi_cfg_regfile

Overview:
- Parametrised SPI (mode 0) configuration register file.
- Unlike the previous programmer, it is clocked entirely by the system clock: SCLK, CS and SDI are oversampled through synchronisers.
- It is addressed per register, supports read-back on SDO, and validates frame length before committing.
- It sits between the external test/config pins and all analog trim/enable fields. Downstream logic slices `cfg_regs` into named fields.

Parameters:
- DATA_W, 8: bits per register.
- N_REGS, 16: number of registers. Must be 2..256.
- ADDR_W, $clog2(N_REGS): address field width. Derived; do not override.
- SYNC_STAGES, 2: flip-flop stages on SCLK/CS/SDI. Must be at least 2.
- RST_VAL, {N_REGS*DATA_W{1'b0}}: flat reset image of the register file. Register i occupies bits [i*DATA_W +: DATA_W].

Ports:
- clk  in  1  system clock. Must run at least 8x the SCLK frequency.
- reset  in  1  asynchronous, active-high reset.
- SCLK  in  1  SPI clock, asynchronous to clk.
- CS  in  1  SPI chip select, active low, asynchronous to clk.
- SDI  in  1  SPI serial data in.
- SDO  out  1  serial read data.
- SDO_OE  out  1  pad output enable for SDO.
- cfg_regs  out  N_REGS*DATA_W  register contents (flat vector).
- wr_strobe  out  1  one-cycle pulse on every successful commit.
- wr_addr  out  ADDR_W  address of the last commit. Holds its value between commits.
- frame_err  out  1  one-cycle pulse when a frame is discarded.

Behaviour:
- Reset values:
  - cfg_regs = RST_VAL
  - SDO = 0, SDO_OE = 0
  - wr_strobe = 0, wr_addr = 0, frame_err = 0
  - FSM in IDLE
  - bit counter = 0, shift registers = 0
- Reset may assert at any time, including mid-frame. The frame in progress is lost and the block returns to the reset values above.
- Synchronisation and edge detection:
  - SCLK, CS and SDI each pass through SYNC_STAGES flops.
  - Edge detection uses one further flop on each synchronised signal.
  - This produces `sclk_rise`, `sclk_fall`, `cs_fall` and `cs_rise` as single-cycle pulses.
- Frame format, MSB first, F = 1 + ADDR_W + DATA_W bits:
  - bit 0: RW (1 = read, 0 = write)
  - next ADDR_W bits: address
  - last DATA_W bits: data
- SDI is sampled on `sclk_rise`, and only while synchronised CS is low. Shifting uses a left shift with the new bit entering at the LSB.
- SCLK edges while CS is high are ignored.
- FSM states:
  - IDLE: on `cs_fall`, clear the counter and go to HDR.
  - HDR: count header bits. When 1+ADDR_W bits have been received, latch RW and address.
    - Read with address < N_REGS: load `tx_sr` with register[addr], then go to DATA.
    - Read with address >= N_REGS: load `tx_sr` with 0, then go to DATA.
    - Write: go to DATA.
  - DATA: count DATA_W bits. After the F-th bit, go to OVR.
  - OVR: any further `sclk_rise` sets the sticky flag `ovf`.
  - From any non-IDLE state, `cs_rise` performs the end-of-frame evaluation below, then returns to IDLE.
- End-of-frame evaluation on `cs_rise`:
  - Commit when all hold: write frame, exactly F bits received, `ovf` = 0, address < N_REGS.
    - On the next clk, register[addr] is updated with the data.
    - wr_strobe pulses for one cycle and wr_addr is updated.
    - Latency from the raw CS rise to the wr_strobe cycle is SYNC_STAGES+2 clk cycles.
  - Discard in every other write case:
    - fewer than F bits received
    - more than F bits received
    - address out of range
    - A discard pulses frame_err for one cycle, with the same latency as a commit. No register changes.
  - Read frames never modify registers. They still pulse frame_err when the bit count ≠ F.
- Read-back:
  - SDO_OE = 1 while in DATA or OVR for a read frame; 0 otherwise.
  - SDO presents `tx_sr[DATA_W-1]`. `tx_sr` shifts left on each `sclk_fall` in DATA.
  - The first data bit is valid before the first data-phase SCLK rise, because the load occurs on the last header `sclk_rise`.
  - In OVR, SDO = 0.
- Simultaneous events:
  - `cs_rise` and `sclk_rise` in the same cycle: the bit is counted first, then the end-of-frame check is applied.
  - `cs_fall` while not in IDLE cannot occur. If forced by glitching, the FSM restarts in HDR.
- All outputs are registered. cfg_regs changes only on commit or reset.

Decomposition:
- Package `spi_cfg_pkg`:
  - enum `spi_state_t` {IDLE, HDR, DATA, OVR}
  - localparam function for F
  - RW encoding constants RW_READ = 1, RW_WRITE = 0
- Sub-module `sync_edge_det`:
  - Parameter STAGES.
  - Inputs: clk, reset, async_in.
  - Outputs: `sync_out`, `rise`, `fall`.
  - Instantiated three times (SCLK, CS, SDI; the SDI instance uses `sync_out` only).

Test Plan (DATA_W=8, N_REGS=16, F=13, clk = 10x SCLK):
- Reset → cfg_regs == RST_VAL (use pattern 0x…0F0E…01), SDO_OE == 0, no pulses.
- Write frame 0_0011_10100101 → reg3 == 0xA5 and all others unchanged. wr_strobe is exactly 1 cycle, SYNC_STAGES+2 clk after CS rises, with wr_addr == 3.
- Read frame 1_0011_xxxxxxxx after the above → SDO returns 10100101 sampled on SCLK rises, SDO_OE high only during the data phase, no register change, no frame_err.
- Write of 12 bits, then a write of 14 bits, both to reg5 → reg5 unchanged, two frame_err pulses, no wr_strobe.
- SCLK toggling with CS high, then reset asserted mid-frame after 6 bits → no shifts while CS is high; after reset, state is IDLE, registers equal RST_VAL, and a following valid write to reg15 = 0xFF commits.
- With N_REGS=12, write to address 13 → frame_err pulse; read of address 13 → SDO all zeros.
